// File: rtl/vga_layer_mixer_if.sv
// Pixel/config/output bundle between the graphics front end and vga_layer_mixer.
// master drives pixels and configuration; slave (the mixer) drives the VGA pins.
interface vga_layer_mixer_if #(
   parameter int NUM_LAYERS     = 4,
   parameter int COLOR_BITS     = 8,
   parameter int FRAME_CNT_BITS = 8
);
   logic                      pixel_en;
   logic                      video_on_in;
   logic                      h_sync_in;
   logic                      v_sync_in;
   logic [NUM_LAYERS-1:0]     layer_red;
   logic [NUM_LAYERS-1:0]     layer_green;
   logic [NUM_LAYERS-1:0]     layer_blue;
   logic                      mode;
   logic [NUM_LAYERS-1:0]     layer_enable;
   logic [NUM_LAYERS-1:0]     blink_mask;
   logic [2:0]                bg_rgb;
   logic [COLOR_BITS-1:0]     vga_red;
   logic [COLOR_BITS-1:0]     vga_green;
   logic [COLOR_BITS-1:0]     vga_blue;
   logic                      video_on_out;
   logic                      h_sync_out;
   logic                      v_sync_out;
   logic [FRAME_CNT_BITS-1:0] frame_count;

   modport master (
      output pixel_en, video_on_in, h_sync_in, v_sync_in,
      output layer_red, layer_green, layer_blue,
      output mode, layer_enable, blink_mask, bg_rgb,
      input  vga_red, vga_green, vga_blue,
      input  video_on_out, h_sync_out, v_sync_out, frame_count
   );

   modport slave (
      input  pixel_en, video_on_in, h_sync_in, v_sync_in,
      input  layer_red, layer_green, layer_blue,
      input  mode, layer_enable, blink_mask, bg_rgb,
      output vga_red, vga_green, vga_blue,
      output video_on_out, h_sync_out, v_sync_out, frame_count
   );
endinterface

// File: rtl/vga_layer_mixer.sv
// N-layer 1-bit-RGB compositor (OR or priority mode) with frame-shadowed config,
// per-layer blink and a two-strobe pipeline keeping syncs aligned with colour.
module vga_layer_mixer #(
   parameter int NUM_LAYERS     = 4,
   parameter int COLOR_BITS     = 8,
   parameter int FRAME_CNT_BITS = 8,
   parameter int BLINK_SHIFT    = 4
) (
   input  logic              clock_50,
   input  logic              reset_n,
   vga_layer_mixer_if.slave  bus
);

   logic [NUM_LAYERS-1:0]     s1_r_q, s1_g_q, s1_b_q;
   logic                      s1_vid_q, s1_hs_q, s1_vs_q;
   logic [2:0]                rgb_q, rgb_d;
   logic                      vid_q, hs_q, vs_q;
   logic [FRAME_CNT_BITS-1:0] fcnt_q, fcnt_d;
   logic                      sh_mode_q;
   logic [NUM_LAYERS-1:0]     sh_en_q, sh_blink_q;
   logic [2:0]                sh_bg_q;

   logic                      frame_start;
   logic [NUM_LAYERS-1:0]     eff_en, opaque;
   logic [2:0]                or_rgb, pri_rgb;

   // s1_vs_q doubles as the previous v_sync sample for edge detection
   always_comb begin
      frame_start = bus.pixel_en & s1_vs_q & ~bus.v_sync_in;
      fcnt_d      = fcnt_q + FRAME_CNT_BITS'(1);
      eff_en      = sh_en_q & ~(fcnt_q[BLINK_SHIFT] ? sh_blink_q : '0);
      opaque      = eff_en & (s1_r_q | s1_g_q | s1_b_q);
      or_rgb      = {|(s1_r_q & eff_en), |(s1_g_q & eff_en), |(s1_b_q & eff_en)};
      pri_rgb     = '0;
      // scan from the highest index down so the lowest opaque layer wins
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
         if (opaque[NUM_LAYERS-1-i])
            pri_rgb = {s1_r_q[NUM_LAYERS-1-i], s1_g_q[NUM_LAYERS-1-i],
                       s1_b_q[NUM_LAYERS-1-i]};
      end
      if (!s1_vid_q)
         rgb_d = '0;
      else if (~|opaque)
         rgb_d = sh_bg_q;
      else
         rgb_d = sh_mode_q ? pri_rgb : or_rgb;
   end

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         s1_r_q     <= '0;
         s1_g_q     <= '0;
         s1_b_q     <= '0;
         s1_vid_q   <= 1'b0;
         s1_hs_q    <= 1'b1;
         s1_vs_q    <= 1'b1;
         rgb_q      <= '0;
         vid_q      <= 1'b0;
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
         fcnt_q     <= '0;
         sh_mode_q  <= 1'b0;
         sh_en_q    <= '1;
         sh_blink_q <= '0;
         sh_bg_q    <= '0;
      end else if (bus.pixel_en) begin
         s1_r_q   <= bus.layer_red;
         s1_g_q   <= bus.layer_green;
         s1_b_q   <= bus.layer_blue;
         s1_vid_q <= bus.video_on_in;
         s1_hs_q  <= bus.h_sync_in;
         s1_vs_q  <= bus.v_sync_in;
         rgb_q    <= rgb_d;
         vid_q    <= s1_vid_q;
         hs_q     <= s1_hs_q;
         vs_q     <= s1_vs_q;
         if (frame_start) begin
            fcnt_q     <= fcnt_d;
            sh_mode_q  <= bus.mode;
            sh_en_q    <= bus.layer_enable;
            sh_blink_q <= bus.blink_mask;
            sh_bg_q    <= bus.bg_rgb;
         end
      end
   end

   assign bus.vga_red      = {COLOR_BITS{rgb_q[2]}};
   assign bus.vga_green    = {COLOR_BITS{rgb_q[1]}};
   assign bus.vga_blue     = {COLOR_BITS{rgb_q[0]}};
   assign bus.video_on_out = vid_q;
   assign bus.h_sync_out   = hs_q;
   assign bus.v_sync_out   = vs_q;
   assign bus.frame_count  = fcnt_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed bench for vga_layer_mixer: latency, OR/priority mixing, shadowing,
// background, blanking, blink with frame-counter wrap, pixel_en hold and async reset.
module tb_vga_layer_mixer;

   logic clock_50;
   logic reset_n;
   int   checks;
   int   errors;
   logic [7:0] exp_fc;

   vga_layer_mixer_if #(.NUM_LAYERS(4), .COLOR_BITS(8), .FRAME_CNT_BITS(8)) bus ();

   vga_layer_mixer #(
      .NUM_LAYERS(4), .COLOR_BITS(8), .FRAME_CNT_BITS(8), .BLINK_SHIFT(0)
   ) dut (
      .clock_50 (clock_50),
      .reset_n  (reset_n),
      .bus      (bus)
   );

   initial clock_50 = 1'b0;
   always #10 clock_50 = ~clock_50;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic strobe();
      bus.pixel_en = 1'b1;
      @(posedge clock_50);
      #1;
   endtask

   // one strobe carrying a v_sync falling edge
   task automatic fs_strobe();
      bus.v_sync_in = 1'b0;
      strobe();
      bus.v_sync_in = 1'b1;
      exp_fc = exp_fc + 8'd1;
   endtask

   task automatic set_layers(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
      bus.layer_red   = r;
      bus.layer_green = g;
      bus.layer_blue  = b;
   endtask

   function automatic logic [31:0] rgb();
      return {8'h00, bus.vga_red, bus.vga_green, bus.vga_blue};
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      exp_fc = 8'd0;
      reset_n = 1'b1;
      bus.pixel_en = 1'b0;
      bus.video_on_in = 1'b0;
      bus.h_sync_in = 1'b1;
      bus.v_sync_in = 1'b1;
      set_layers(4'b0000, 4'b0000, 4'b0000);
      bus.mode = 1'b0;
      bus.layer_enable = 4'b1111;
      bus.blink_mask = 4'b0000;
      bus.bg_rgb = 3'b000;
      #2 reset_n = 1'b0;
      #25;
      check("reset_rgb", rgb(), 32'h000000);
      check("reset_vid", 32'(bus.video_on_out), 32'd0);
      check("reset_hs", 32'(bus.h_sync_out), 32'd1);
      check("reset_vs", 32'(bus.v_sync_out), 32'd1);
      check("reset_fc", 32'(bus.frame_count), 32'd0);
      @(negedge clock_50);
      reset_n = 1'b1;

      // latency: two strobes for blank and sync
      bus.video_on_in = 1'b1;
      bus.h_sync_in = 1'b0;
      strobe();
      check("lat1_vid", 32'(bus.video_on_out), 32'd0);
      check("lat1_hs", 32'(bus.h_sync_out), 32'd1);
      bus.h_sync_in = 1'b1;
      strobe();
      check("lat2_vid", 32'(bus.video_on_out), 32'd1);
      check("lat2_hs", 32'(bus.h_sync_out), 32'd0);
      check("lat2_rgb", rgb(), 32'h000000);

      // OR mode: layer0=100, layer1=010
      set_layers(4'b0001, 4'b0010, 4'b0000);
      strobe();
      strobe();
      check("or_mix", rgb(), 32'hFFFF00);

      // priority mode: layer0=001, layer1=110
      bus.mode = 1'b1;
      fs_strobe();
      set_layers(4'b0010, 4'b0010, 4'b0001);
      strobe();
      strobe();
      check("pri_mix", rgb(), 32'h0000FF);
      check("fc_one", 32'(bus.frame_count), 32'(exp_fc));
      bus.layer_enable = 4'b1110;
      strobe();
      check("pri_no_fs", rgb(), 32'h0000FF);
      fs_strobe();
      check("pri_fs_old", rgb(), 32'h0000FF);
      strobe();
      check("pri_fs_new", rgb(), 32'hFFFF00);

      // background and blanking
      bus.layer_enable = 4'b1111;
      bus.bg_rgb = 3'b011;
      set_layers(4'b0000, 4'b0000, 4'b0000);
      fs_strobe();
      strobe();
      check("bg_active", rgb(), 32'h00FFFF);
      bus.video_on_in = 1'b0;
      strobe();
      strobe();
      check("bg_blank", rgb(), 32'h000000);
      bus.video_on_in = 1'b1;

      // blink on layer0 with BLINK_SHIFT=0
      bus.mode = 1'b0;
      bus.blink_mask = 4'b0001;
      bus.bg_rgb = 3'b000;
      set_layers(4'b0001, 4'b0000, 4'b0000);
      fs_strobe();
      for (int i = 0; i < 4; i++) begin
         strobe();
         check($sformatf("blink_%0d", i), 32'(bus.vga_red), exp_fc[0] ? 32'h00 : 32'hFF);
         fs_strobe();
      end
      while (exp_fc != 8'd255) begin
         strobe();
         fs_strobe();
      end
      strobe();
      check("fc_255", 32'(bus.frame_count), 32'd255);
      fs_strobe();
      check("fc_wrap", 32'(bus.frame_count), 32'd0);
      strobe();
      check("blink_wrap", rgb(), 32'hFF0000);

      // pixel_en hold: frame 1 is a blink-off frame, bg shows green
      bus.bg_rgb = 3'b010;
      fs_strobe();
      strobe();
      check("pre_hold", rgb(), 32'h00FF00);
      bus.pixel_en = 1'b0;
      set_layers(4'b1111, 4'b1111, 4'b1111);
      bus.video_on_in = 1'b0;
      bus.h_sync_in = 1'b0;
      bus.v_sync_in = 1'b0;
      bus.bg_rgb = 3'b111;
      bus.mode = 1'b1;
      repeat (10) @(posedge clock_50);
      #1;
      check("hold_rgb", rgb(), 32'h00FF00);
      check("hold_vid", 32'(bus.video_on_out), 32'd1);
      check("hold_hs", 32'(bus.h_sync_out), 32'd1);
      check("hold_vs", 32'(bus.v_sync_out), 32'd0);
      check("hold_fc", 32'(bus.frame_count), 32'd1);

      // async reset mid-line
      bus.pixel_en = 1'b1;
      @(posedge clock_50);
      #4;
      reset_n = 1'b0;
      #1;
      check("areset_rgb", rgb(), 32'h000000);
      check("areset_vid", 32'(bus.video_on_out), 32'd0);
      check("areset_hs", 32'(bus.h_sync_out), 32'd1);
      check("areset_vs", 32'(bus.v_sync_out), 32'd1);
      check("areset_fc", 32'(bus.frame_count), 32'd0);
      #20;
      reset_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
